// File: rtl/dbus_uncached_bridge_pkg.sv
// ============================================================================
// dbus_uncached_bridge_pkg
// Shared types for the uncached data-bus bridge: write-buffer entry, FSM states.
// Revision: 1.0
// ============================================================================
`default_nettype none

package dbus_uncached_bridge_pkg;

    // Entry address width; the bridge ADDR_WIDTH parameter defaults to this.
    localparam int DBUS_ADDR_WIDTH = 32;

    typedef struct packed {
        logic [DBUS_ADDR_WIDTH-1:0] addr;
        logic [3:0]                 be;
        logic [31:0]                wdata;
    } wbuf_entry_t;

    typedef logic [2:0] dbus_state_t;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_DRAIN   = 3'd1;
    localparam logic [2:0] ST_RD_REQ  = 3'd2;
    localparam logic [2:0] ST_RD_WAIT = 3'd3;
    localparam logic [2:0] ST_RESP    = 3'd4;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_d,
                                                input logic [31:0] new_d,
                                                input logic [3:0]  be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = be[b] ? new_d[8*b +: 8] : old_d[8*b +: 8];
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dbus_uncached_bridge_wbuf_fifo.sv
// ============================================================================
// wbuf_fifo
// In-order write buffer with push/pop and a tail-entry rewrite port for merging.
// Revision: 1.0
// ============================================================================
`default_nettype none

module wbuf_fifo
    import dbus_uncached_bridge_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  wbuf_entry_t            push_data_i,
    input  logic                   pop_i,
    input  logic                   merge_i,
    input  wbuf_entry_t            merge_data_i,
    output wbuf_entry_t            head_o,
    output wbuf_entry_t            next_o,
    output wbuf_entry_t            tail_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int PW = $clog2(DEPTH);

    wbuf_entry_t   mem_q [DEPTH];
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [PW:0]   count_q;

    assign head_o  = mem_q[head_q];
    assign next_o  = mem_q[head_q + PW'(1)];
    assign tail_o  = mem_q[tail_q - PW'(1)];
    assign count_o = count_q;
    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[tail_q] <= push_data_i;
        end
        if (merge_i) begin
            mem_q[tail_q - PW'(1)] <= merge_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                tail_q <= tail_q + PW'(1);
            end
            if (pop_i) begin
                head_q <= head_q + PW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/dbus_uncached_bridge.sv
// ============================================================================
// dbus_uncached_bridge
// Posted uncached stores via an in-order write buffer; loads wait behind them.
// Optional store merging into the tail entry: define DBUS_WBUF_MERGE_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dbus_uncached_bridge
    import dbus_uncached_bridge_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = DBUS_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [3:0]            req_be,
    input  logic [31:0]           req_wdata,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  wbuf_empty,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata
);

    localparam int CW = $clog2(DEPTH) + 1;

    dbus_state_t           state_q, state_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]            mem_be_q, mem_be_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic [31:0]           rdata_q, rdata_d;

    logic [ADDR_WIDTH-1:0] w_req_waddr;
    wbuf_entry_t           w_req_entry;
    wbuf_entry_t           w_head;
    wbuf_entry_t           w_next;
    wbuf_entry_t           w_cand;
    wbuf_entry_t           w_merge_entry;
    logic [CW-1:0]         w_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_in_idle;
    logic                  w_drain_st;
    logic                  w_pop;
    logic                  w_merge_hit;
    logic                  w_store_acc;
    logic                  w_push;
    logic                  w_merge;
    logic                  w_have_fifo;
    logic                  w_wr_launch;
    logic                  w_rd_launch;
    logic                  w_drain_done;
    logic                  w_wbuf_empty;

    assign w_req_waddr = req_addr & ~ADDR_WIDTH'(3);
    assign w_req_entry = '{addr: DBUS_ADDR_WIDTH'(w_req_waddr), be: req_be, wdata: req_wdata};

    assign w_in_idle  = (state_q == ST_IDLE);
    assign w_drain_st = w_in_idle || (state_q == ST_DRAIN);
    assign w_pop      = mem_req_q & mem_we_q & mem_gnt;

`ifdef DBUS_WBUF_MERGE_EN
    wbuf_entry_t w_tail;

    // The tail must not be the head on the bus, nor the entry launched this cycle.
    assign w_merge_hit = (w_count >= CW'(2)) && (w_tail.addr == w_req_entry.addr) &&
                         !(w_pop && (w_count == CW'(2)));
    assign w_merge_entry = '{addr:  w_tail.addr,
                             be:    w_tail.be | req_be,
                             wdata: merge_bytes(w_tail.wdata, req_wdata, req_be)};
`else
    assign w_merge_hit   = 1'b0;
    assign w_merge_entry = w_req_entry;
`endif

    assign w_store_acc = req_valid & req_we & w_in_idle & (~w_full | w_merge_hit);
    assign w_push      = w_store_acc & ~w_merge_hit;
    assign w_merge     = w_store_acc & w_merge_hit;

    // Next write to present: the entry behind any popping head, else the incoming store.
    assign w_have_fifo  = w_pop ? (w_count > CW'(1)) : (w_count != '0);
    assign w_cand       = w_have_fifo ? (w_pop ? w_next : w_head) : w_req_entry;
    assign w_wr_launch  = w_drain_st & (~mem_req_q | mem_gnt) & (w_have_fifo | w_push);
    assign w_drain_done = w_pop ? (w_count == CW'(1)) : (w_count == '0);
    assign w_wbuf_empty = w_empty & ~(mem_req_q & mem_we_q);

    wbuf_fifo #(
        .DEPTH(DEPTH)
    ) u_wbuf_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (w_push),
        .push_data_i  (w_req_entry),
        .pop_i        (w_pop),
        .merge_i      (w_merge),
        .merge_data_i (w_merge_entry),
        .head_o       (w_head),
        .next_o       (w_next),
`ifdef DBUS_WBUF_MERGE_EN
        .tail_o       (w_tail),
`else
        .tail_o       (),
`endif
        .count_o      (w_count),
        .full_o       (w_full),
        .empty_o      (w_empty)
    );

    always_comb begin
        state_d     = state_q;
        rdata_d     = rdata_q;
        w_rd_launch = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && !req_we) begin
                    if (w_wbuf_empty) begin
                        state_d     = ST_RD_REQ;
                        w_rd_launch = 1'b1;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_drain_done) begin
                    state_d     = ST_RD_REQ;
                    w_rd_launch = 1'b1;
                end
            end
            ST_RD_REQ: begin
                if (mem_gnt) begin
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (mem_rvalid) begin
                    rdata_d = mem_rdata;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        if (w_wr_launch) begin
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = ADDR_WIDTH'(w_cand.addr);
            mem_be_d    = w_cand.be;
            mem_wdata_d = w_cand.wdata;
        end else if (w_rd_launch) begin
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = w_req_waddr;
            mem_be_d   = 4'hF;
        end else if (mem_req_q && mem_gnt) begin
            mem_req_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    assign req_ready  = w_store_acc | (state_q == ST_RESP);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = rdata_q;
    assign wbuf_empty = w_wbuf_empty;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_dbus_uncached_bridge.sv
// ============================================================================
// tb_dbus_uncached_bridge
// Directed self-checking bench for dbus_uncached_bridge.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dbus_uncached_bridge;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    wire logic        req_ready;
    wire logic        resp_valid;
    wire logic [31:0] resp_rdata;
    wire logic        wbuf_empty;
    wire logic        mem_req;
    wire logic        mem_we;
    wire logic [31:0] mem_addr;
    wire logic [3:0]  mem_be;
    wire logic [31:0] mem_wdata;
    logic        gnt_en;
    logic [31:0] rd_data;
    int          rd_lat;
    int          rd_cnt;
    wire logic   mem_gnt;
    wire logic   mem_rvalid;

    int n_checks;
    int n_pass;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } txn_t;
    txn_t log_q[$];

    assign mem_gnt    = gnt_en;
    assign mem_rvalid = (rd_cnt == 1);

    dbus_uncached_bridge #(
        .DEPTH      (4),
        .ADDR_WIDTH (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_be     (req_be),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .wbuf_empty (wbuf_empty),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: log granted transactions, return read data rd_lat cycles after grant.
    always @(posedge clk) begin
        if (mem_req && mem_gnt) begin
            log_q.push_back('{we: mem_we, addr: mem_addr, be: mem_be, wdata: mem_wdata});
        end
        if (mem_req && !mem_we && mem_gnt) begin
            rd_cnt <= rd_lat;
        end else if (rd_cnt != 0) begin
            rd_cnt <= rd_cnt - 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                            output int waited);
        waited    = 0;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = a;
        req_be    = be;
        req_wdata = d;
        #1;
        while (!req_ready && waited < 50) begin
            @(posedge clk); #2;
            waited++;
        end
        if (!req_ready) chk("store_accept_timeout", 0, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a, output int lat, output logic [31:0] data,
                           output logic rv);
        lat       = 0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = a;
        #1;
        while (!req_ready && lat < 100) begin
            @(posedge clk); #2;
            lat++;
        end
        if (!req_ready) chk("load_accept_timeout", 0, 1);
        data = resp_rdata;
        rv   = resp_valid;
        @(posedge clk); #1;
        req_valid = 1'b0;
        #1;
        chk("resp_single_cycle", resp_valid, 0);
    endtask

    task automatic wait_empty(input int max_cyc);
        for (int i = 0; i < max_cyc && !wbuf_empty; i++) begin
            @(posedge clk); #1;
        end
        chk("drain_complete", wbuf_empty, 1);
    endtask

    initial begin
        int          w;
        int          tot;
        int          lat;
        logic [31:0] data;
        logic        rv;
        logic        seen;

        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_be    = '0;
        req_wdata = '0;
        gnt_en    = 1'b0;
        rd_data   = '0;
        rd_lat    = 1;
        rd_cnt    = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_wbuf_empty", wbuf_empty, 1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single posted store with an always-granting memory.
        gnt_en = 1'b1;
        log_q.delete();
        do_store(32'h1FD0_03F8, 4'hF, 32'hDEAD_BEEF, w);
        chk("t1_ready_same_cycle", w, 0);
        chk("t1_mem_req", mem_req, 1);
        chk("t1_mem_we", mem_we, 1);
        chk("t1_mem_addr", mem_addr, 32'h1FD0_03F8);
        chk("t1_mem_be", mem_be, 4'hF);
        chk("t1_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("t1_wbuf_busy", wbuf_empty, 0);
        @(posedge clk); #1;
        chk("t1_wbuf_empty_again", wbuf_empty, 1);
        chk("t1_req_dropped", mem_req, 0);

        // Fill to DEPTH with a stalled memory; the fifth store waits for a pop.
        gnt_en = 1'b0;
        log_q.delete();
        tot = 0;
        for (int i = 0; i < 4; i++) begin
            do_store(32'h100 + 32'(4 * i), 4'hF, 32'hA0 + 32'(i), w);
            tot += w;
        end
        chk("t2_four_no_wait", tot, 0);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h110;
        req_be    = 4'hF;
        req_wdata = 32'hA4;
        #1;
        chk("t2_fifth_stalls", req_ready, 0);
        @(posedge clk); #1;
        gnt_en = 1'b1;
        #1;
        chk("t2_no_accept_on_pop_cycle", req_ready, 0);
        @(posedge clk); #2;
        chk("t2_accept_after_pop", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        wait_empty(50);
        chk("t2_write_count", log_q.size(), 5);
        for (int i = 0; i < 5 && i < log_q.size(); i++) begin
            chk("t2_order_addr", log_q[i].addr, 32'h100 + 32'(4 * i));
            chk("t2_order_data", log_q[i].wdata, 32'hA0 + 32'(i));
        end

        // Stores then a load: the read must follow both writes.
        log_q.delete();
        rd_lat  = 2;
        rd_data = 32'h1234_5678;
        do_store(32'h200, 4'hF, 32'h1111_1111, w);
        do_store(32'h204, 4'hF, 32'h2222_2222, w);
        do_load(32'h1FD0_03FC, lat, data, rv);
        chk("t3_resp_valid", rv, 1);
        chk("t3_rdata", data, 32'h1234_5678);
        chk("t3_txn_count", log_q.size(), 3);
        if (log_q.size() == 3) begin
            chk("t3_w0_addr", log_q[0].addr, 32'h200);
            chk("t3_w1_addr", log_q[1].addr, 32'h204);
            chk("t3_rd_is_read", log_q[2].we, 0);
            chk("t3_rd_addr", log_q[2].addr, 32'h1FD0_03FC);
            chk("t3_rd_be", log_q[2].be, 4'hF);
        end

        // Empty buffer, zero-wait memory: accepted three cycles after the request.
        log_q.delete();
        rd_lat  = 1;
        rd_data = 32'hCAFE_F00D;
        do_load(32'h0000_1002, lat, data, rv);
        chk("t4_latency", lat, 3);
        chk("t4_rdata", data, 32'hCAFE_F00D);
        chk("t4_aligned_addr", (log_q.size() > 0) ? log_q[0].addr : 32'hFFFF_FFFF, 32'h1000);

        // Reset while waiting for read data; the late rvalid must be ignored.
        rd_lat    = 6;
        rd_data   = 32'h55AA_55AA;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h3000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t5_rd_granted", mem_req, 0);
        rst       = 1'b1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (resp_valid) seen = 1'b1;
        end
        chk("t5_no_late_resp", seen, 0);
        chk("t5_req_ready", req_ready, 0);
        chk("t5_resp_rdata", resp_rdata, 0);
        chk("t5_mem_req", mem_req, 0);
        chk("t5_mem_we", mem_we, 0);
        chk("t5_mem_addr", mem_addr, 0);
        chk("t5_mem_be", mem_be, 0);
        chk("t5_mem_wdata", mem_wdata, 0);
        chk("t5_wbuf_empty", wbuf_empty, 1);
        rd_lat  = 1;
        rd_data = 32'h0BAD_F00D;
        do_load(32'h4000, lat, data, rv);
        chk("t5_post_reset_latency", lat, 3);
        chk("t5_post_reset_rdata", data, 32'h0BAD_F00D);

        // Two partial stores to one word behind a stalled head.
        gnt_en = 1'b0;
        log_q.delete();
        do_store(32'h400, 4'hF, 32'h0, w);
        do_store(32'h500, 4'h3, 32'h0000_AAAA, w);
        do_store(32'h500, 4'hC, 32'hBBBB_0000, w);
        gnt_en = 1'b1;
        wait_empty(50);
`ifdef DBUS_WBUF_MERGE_EN
        chk("t6_merged_count", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("t6_merged_addr", log_q[1].addr, 32'h500);
            chk("t6_merged_be", log_q[1].be, 4'hF);
            chk("t6_merged_data", log_q[1].wdata, 32'hBBBB_AAAA);
        end
`else
        chk("t6_unmerged_count", log_q.size(), 3);
        if (log_q.size() == 3) begin
            chk("t6_first_be", log_q[1].be, 4'h3);
            chk("t6_first_data", log_q[1].wdata, 32'h0000_AAAA);
            chk("t6_second_be", log_q[2].be, 4'hC);
            chk("t6_second_data", log_q[2].wdata, 32'hBBBB_0000);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
